// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with write-to-read bypass and a per-register
// busy scoreboard. Decode reserves a destination (rsv_en), writeback writes
// and releases it (we). Register 0 can be hard-wired to zero.
module regfile_2r1w_sb #(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [DW-1:0] rd_data_a,
   output logic [DW-1:0] rd_data_b,
   output logic          rd_valid,
   input  logic          rsv_en,
   input  logic [AW-1:0] rsv_addr,
   output logic          busy_a,
   output logic          busy_b
);

   // DEPTH widened by one bit so that DEPTH == 2**AW still compares correctly
   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

   logic [DW-1:0] regs_q [DEPTH];
   logic [DW-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [DW-1:0] rd_data_a_q, rd_data_a_d;
   logic [DW-1:0] rd_data_b_q, rd_data_b_d;
   logic          rd_valid_q, rd_valid_d;

   // An address is "live" when it maps to a real, writable register
   logic wr_ok, rsv_ok, rd_ok_a, rd_ok_b;
   logic hit_a, hit_b;
   logic [DW-1:0] val_a, val_b;

   // Classify every address port and form the read values, including bypass
   always_comb begin
      wr_ok   = we     && ({1'b0, wr_addr}   < DEPTH_W) && !(ZERO_REG && wr_addr   == '0);
      rsv_ok  = rsv_en && ({1'b0, rsv_addr}  < DEPTH_W) && !(ZERO_REG && rsv_addr  == '0);
      rd_ok_a =           ({1'b0, rd_addr_a} < DEPTH_W) && !(ZERO_REG && rd_addr_a == '0);
      rd_ok_b =           ({1'b0, rd_addr_b} < DEPTH_W) && !(ZERO_REG && rd_addr_b == '0);
      hit_a   = wr_ok && (wr_addr == rd_addr_a);
      hit_b   = wr_ok && (wr_addr == rd_addr_b);
      val_a   = '0;
      val_b   = '0;
      if (rd_ok_a) val_a = hit_a ? wr_data : regs_q[rd_addr_a];
      if (rd_ok_b) val_b = hit_b ? wr_data : regs_q[rd_addr_b];
   end

   // Next state of storage, scoreboard and read pipeline; reserve beats release
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         busy_d[i] = busy_q[i];
         if (wr_ok && wr_addr == i[AW-1:0]) begin
            regs_d[i] = wr_data;
            busy_d[i] = 1'b0;
         end
         if (rsv_ok && rsv_addr == i[AW-1:0]) begin
            busy_d[i] = 1'b1;
         end
      end
      rd_data_a_d = rd_en ? val_a : rd_data_a_q;
      rd_data_b_d = rd_en ? val_b : rd_data_b_q;
      rd_valid_d  = rd_en;
   end

   // State registers; reset clears everything and drops any pending read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q      <= '0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
         busy_q      <= busy_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   // Busy lookup with same-cycle writeback release forwarded
   always_comb begin
      busy_a = rd_ok_a && busy_q[rd_addr_a] && !hit_a;
      busy_b = rd_ok_b && busy_q[rd_addr_b] && !hit_b;
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb: DEPTH=24 instance so range checks
// (addresses 24..31) are exercised alongside bypass, zero register and scoreboard.
module tb_regfile_2r1w_sb;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic [DW-1:0] rd_data_a, rd_data_b;
   logic          rd_valid;
   logic          rsv_en;
   logic [AW-1:0] rsv_addr;
   logic          busy_a, busy_b;

   int total = 0;
   int bad   = 0;

   regfile_2r1w_sb #(.DW(DW), .DEPTH(24), .AW(AW), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(busy_a), .busy_b(busy_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 0; rd_en = 0; rsv_en = 0;
   endtask

   initial begin
      rst_n = 0; we = 0; wr_addr = 0; wr_data = 0; rd_en = 0;
      rd_addr_a = 0; rd_addr_b = 0; rsv_en = 0; rsv_addr = 0;
      tick(); tick();
      rst_n = 1;
      rd_addr_a = 9; rd_addr_b = 4;
      #1;
      check("rst_valid", {31'b0, rd_valid}, 32'd0);
      check("rst_data_a", rd_data_a, 32'd0);
      check("rst_data_b", rd_data_b, 32'd0);
      check("rst_busy_a", {31'b0, busy_a}, 32'd0);
      check("rst_busy_b", {31'b0, busy_b}, 32'd0);

      // 1: read after reset
      rd_en = 1; rd_addr_a = 3; rd_addr_b = 7;
      tick();
      check("t1_data_a", rd_data_a, 32'd0);
      check("t1_data_b", rd_data_b, 32'd0);
      check("t1_valid", {31'b0, rd_valid}, 32'd1);

      // 2: bypass, then hold with rd_en=0
      we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_en = 1; rd_addr_a = 5; rd_addr_b = 7;
      tick();
      check("t2_bypass_a", rd_data_a, 32'hDEADBEEF);
      check("t2_b_other", rd_data_b, 32'd0);
      we = 1; wr_addr = 7; wr_data = 32'h00000077; rd_en = 0; rd_addr_a = 7;
      tick();
      check("t2_hold_a", rd_data_a, 32'hDEADBEEF);
      check("t2_hold_valid", {31'b0, rd_valid}, 32'd0);
      we = 0; rd_en = 1; rd_addr_a = 5; rd_addr_b = 7;
      tick();
      check("t2_stored_a", rd_data_a, 32'hDEADBEEF);
      check("t2_stored_b", rd_data_b, 32'h00000077);
      rd_addr_a = 7; rd_addr_b = 7;
      tick();
      check("t2_same_a", rd_data_a, 32'h00000077);
      check("t2_same_b", rd_data_b, 32'h00000077);

      // 3: zero register
      we = 1; wr_addr = 0; wr_data = 32'h1234; rd_en = 1; rd_addr_a = 0; rd_addr_b = 0;
      tick();
      check("t3_r0_byp_a", rd_data_a, 32'd0);
      check("t3_r0_byp_b", rd_data_b, 32'd0);
      we = 0;
      tick();
      check("t3_r0_read", rd_data_a, 32'd0);
      rd_en = 0; rsv_en = 1; rsv_addr = 0;
      tick();
      rsv_en = 0;
      #1;
      check("t3_r0_busy", {31'b0, busy_a}, 32'd0);

      // 4: reserve, forwarded release, read back
      rsv_en = 1; rsv_addr = 9;
      tick();
      rsv_en = 0; rd_addr_a = 9; rd_addr_b = 9;
      #1;
      check("t4_busy_a", {31'b0, busy_a}, 32'd1);
      check("t4_busy_b", {31'b0, busy_b}, 32'd1);
      we = 1; wr_addr = 9; wr_data = 32'h55;
      #1;
      check("t4_fwd_release", {31'b0, busy_a}, 32'd0);
      tick();
      we = 0;
      #1;
      check("t4_released", {31'b0, busy_a}, 32'd0);
      rd_en = 1;
      tick();
      check("t4_read_r9", rd_data_a, 32'h55);
      check("t4_valid", {31'b0, rd_valid}, 32'd1);

      // 5: reserve and write same register, same cycle
      idle();
      rsv_en = 1; rsv_addr = 4; we = 1; wr_addr = 4; wr_data = 32'hA5A5A5A5;
      tick();
      idle();
      rd_addr_a = 4;
      #1;
      check("t5_busy_set_wins", {31'b0, busy_a}, 32'd1);
      rd_en = 1;
      tick();
      check("t5_data_written", rd_data_a, 32'hA5A5A5A5);
      rd_en = 0;

      // 6: range boundaries on a 24-entry file
      we = 1; wr_addr = 30; wr_data = 32'hFFFF; rd_en = 1; rd_addr_a = 30; rd_addr_b = 30;
      tick();
      check("t6_oor_byp_a", rd_data_a, 32'd0);
      check("t6_oor_byp_b", rd_data_b, 32'd0);
      we = 1; wr_addr = 23; wr_data = 32'h24; rd_en = 0;
      tick();
      we = 1; wr_addr = 24; wr_data = 32'hBAD; rd_en = 1; rd_addr_a = 23; rd_addr_b = 24;
      tick();
      check("t6_last_valid", rd_data_a, 32'h24);
      check("t6_first_oor", rd_data_b, 32'd0);
      idle();
      rsv_en = 1; rsv_addr = 30;
      tick();
      rsv_en = 0; rd_addr_a = 30;
      #1;
      check("t6_oor_busy", {31'b0, busy_a}, 32'd0);

      // reset mid-stream with a read and a reserve pending
      we = 1; wr_addr = 23; wr_data = 32'h99; rd_en = 1; rd_addr_a = 23; rd_addr_b = 5;
      rsv_en = 1; rsv_addr = 9; rst_n = 0;
      tick();
      check("t6_rst_valid", {31'b0, rd_valid}, 32'd0);
      check("t6_rst_data_a", rd_data_a, 32'd0);
      check("t6_rst_data_b", rd_data_b, 32'd0);
      rst_n = 1; idle();
      rd_addr_a = 4; rd_addr_b = 9;
      #1;
      check("t6_rst_busy4", {31'b0, busy_a}, 32'd0);
      check("t6_rst_busy9", {31'b0, busy_b}, 32'd0);
      rd_en = 1; rd_addr_a = 23; rd_addr_b = 5;
      tick();
      check("t6_rst_r23", rd_data_a, 32'd0);
      check("t6_rst_r5", rd_data_b, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
